// File: rtl/counter_pkg.sv
// Shared definitions for the modulus counter family.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// WRAP / SATURATE are the legal values of a counter's SATURATE parameter.
// clog2 lets users size WIDTH from MOD (WIDTH = clog2(MOD) is the tightest fit).
package counter_pkg;

  localparam int WRAP     = 0;
  localparam int SATURATE = 1;

  // Ceiling log2; clog2(1) = 0, clog2(10) = 4, clog2(16) = 4, clog2(2**32) = 32.
  function automatic int clog2(input longint unsigned value);
    longint unsigned pow;
    int              bits;
    pow  = 64'd1;
    bits = 0;
    while (pow < value) begin
      pow  = pow << 1;
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with clamped parallel load, wrap/saturate limits.
// Latency: load/count effects on count and ovf one clk edge after sampling; tc is combinational.
// Backpressure: none; en is the only stall, cascade by driving the next stage's en from tc.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load, data_in     parallel load (values above MOD-1 clamp to MOD-1)
//   en, up            count enable and direction (1 = increment)
//   count             registered count, always in 0..MOD-1
//   tc                terminal count: en & (up ? count==MOD-1 : count==0)
//   ovf               registered one-cycle pulse per limit event
module mod_updown_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MOD      = 16,
  parameter int     SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Bad parameterisations are rejected at elaboration rather than producing
  // a counter whose range does not fit its register.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..32");
  end
  if (MOD < 2 || counter_pkg::clog2(64'(MOD)) > WIDTH) begin : g_bad_mod
    $error("mod_updown_counter: MOD must be in 2..2**WIDTH");
  end
  if (SATURATE != counter_pkg::WRAP && SATURATE != counter_pkg::SATURATE) begin : g_bad_sat
    $error("mod_updown_counter: SATURATE must be WRAP or SATURATE");
  end

  localparam bit             SAT_MODE = (SATURATE == counter_pkg::SATURATE);
  localparam logic [WIDTH:0] MAX_V    = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] ONE_V    = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0] cnt_ext, din_ext, inc_w, dec_w;
  logic           at_max, at_zero;

  // Extra bit: the incremented value can reach MOD (= 2**WIDTH at full range),
  // and the decrement borrow out of zero lands in the top bit.
  assign cnt_ext = {1'b0, count_q};
  assign din_ext = {1'b0, data_in};
  assign inc_w   = cnt_ext + ONE_V;
  assign dec_w   = cnt_ext - ONE_V;
  assign at_max  = (inc_w > MAX_V);
  assign at_zero = dec_w[WIDTH];

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (load) begin
      count_d = (din_ext > MAX_V) ? MAX_V[WIDTH-1:0] : data_in;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          count_d = inc_w[WIDTH-1:0];
        end else begin
          ovf_d = 1'b1;
          if (!SAT_MODE) count_d = '0;
        end
      end else begin
        if (!at_zero) begin
          count_d = dec_w[WIDTH-1:0];
        end else begin
          ovf_d = 1'b1;
          if (!SAT_MODE) count_d = MAX_V[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  // Not qualified by load: a cascaded stage must gate with its own load.
  assign tc    = en & (up ? at_max : at_zero);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// pops and compares one record per clock edge, 1 ns after the edge.
module tb_mod_updown_counter;

  typedef struct {
    int         sel;   // 0 = wrap DUT, 1 = saturate DUT, 2 = cascade pair
    logic [7:0] cnt;
    logic [1:0] ovf;
    logic       tc;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       w_load = 1'b0, w_en = 1'b0, w_up = 1'b0;
  logic [3:0] w_din = '0;
  logic [3:0] w_count;
  logic       w_tc, w_ovf;

  logic       s_load = 1'b0, s_en = 1'b0, s_up = 1'b0;
  logic [3:0] s_din = '0;
  logic [3:0] s_count;
  logic       s_tc, s_ovf;

  logic       cas_en = 1'b0;
  logic [3:0] c0_count, c1_count;
  logic       c0_tc, c1_tc, c0_ovf, c1_ovf;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .load(w_load), .data_in(w_din), .en(w_en), .up(w_up),
    .count(w_count), .tc(w_tc), .ovf(w_ovf));

  mod_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .load(s_load), .data_in(s_din), .en(s_en), .up(s_up),
    .count(s_count), .tc(s_tc), .ovf(s_ovf));

  mod_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) u_c0 (
    .clk(clk), .rst(rst), .load(1'b0), .data_in(4'd0), .en(cas_en), .up(1'b1),
    .count(c0_count), .tc(c0_tc), .ovf(c0_ovf));

  mod_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) u_c1 (
    .clk(clk), .rst(rst), .load(1'b0), .data_in(4'd0), .en(c0_tc), .up(1'b1),
    .count(c1_count), .tc(c1_tc), .ovf(c1_ovf));

  // Drive one vector before the next rising edge and queue its expected result.
  task automatic vec(input int sel, input logic r, input logic ld, input logic [3:0] din,
                     input logic e, input logic u, input logic [7:0] ec,
                     input logic [1:0] eo, input logic et, input string nm);
    exp_t x;
    @(negedge clk);
    rst    = r;
    w_load = 1'b0; w_en = 1'b0; w_up = 1'b0; w_din = '0;
    s_load = 1'b0; s_en = 1'b0; s_up = 1'b0; s_din = '0;
    cas_en = 1'b0;
    case (sel)
      0:       begin w_load = ld; w_din = din; w_en = e; w_up = u; end
      1:       begin s_load = ld; s_din = din; s_en = e; s_up = u; end
      default: cas_en = e;
    endcase
    x.sel = sel; x.cnt = ec; x.ovf = eo; x.tc = et; x.name = nm;
    q.push_back(x);
  endtask

  // Monitor: every edge that has a pending expectation gets checked.
  initial begin
    exp_t       x;
    logic [7:0] ac;
    logic [1:0] ao;
    logic       at;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        case (x.sel)
          0:       begin ac = {4'd0, w_count}; ao = {1'b0, w_ovf}; at = w_tc; end
          1:       begin ac = {4'd0, s_count}; ao = {1'b0, s_ovf}; at = s_tc; end
          default: begin ac = {c1_count, c0_count}; ao = {c1_ovf, c0_ovf}; at = c1_tc; end
        endcase
        n_vec++;
        if (ac !== x.cnt || ao !== x.ovf || at !== x.tc) begin
          n_miss++;
          $display("FAIL %s: got count=%h ovf=%b tc=%b, expected count=%h ovf=%b tc=%b",
                   x.name, ac, ao, at, x.cnt, x.ovf, x.tc);
        end
      end
    end
  end

  initial begin
    int v;
    // Wrap DUT, MOD=10.  args: sel rst load din en up | count ovf tc
    vec(0, 1, 0, 0,  0, 0, 8'd0, 2'b00, 0, "rst_en0");
    vec(0, 1, 0, 0,  1, 0, 8'd0, 2'b00, 1, "rst_en1_down_tc");
    vec(0, 0, 1, 7,  0, 0, 8'd7, 2'b00, 0, "load7");
    vec(0, 0, 1, 13, 0, 0, 8'd9, 2'b00, 0, "load13_clamp");
    vec(0, 0, 1, 8,  0, 0, 8'd8, 2'b00, 0, "load8");
    vec(0, 0, 0, 0,  1, 1, 8'd9, 2'b00, 1, "up_8to9_tc");
    vec(0, 0, 0, 0,  1, 1, 8'd0, 2'b01, 0, "up_wrap_9to0");
    vec(0, 0, 0, 0,  1, 1, 8'd1, 2'b00, 0, "up_0to1");
    vec(0, 0, 0, 0,  0, 1, 8'd1, 2'b00, 0, "en0_hold");
    vec(0, 0, 1, 9,  0, 0, 8'd9, 2'b00, 0, "load9");
    vec(0, 0, 1, 3,  1, 1, 8'd3, 2'b00, 0, "load_beats_en_at_max");
    vec(0, 0, 0, 0,  1, 0, 8'd2, 2'b00, 0, "dir_change_down");
    vec(0, 0, 1, 0,  0, 0, 8'd0, 2'b00, 0, "load0");
    vec(0, 0, 0, 0,  1, 0, 8'd9, 2'b01, 0, "down_wrap_0to9");
    vec(0, 0, 0, 0,  0, 0, 8'd9, 2'b00, 0, "en0_hold_ovf_clear");
    vec(0, 1, 1, 5,  0, 0, 8'd0, 2'b00, 0, "rst_beats_load");
    // Saturate DUT, MOD=10.
    vec(1, 0, 1, 1,  0, 0, 8'd1, 2'b00, 0, "sat_load1");
    vec(1, 0, 0, 0,  1, 0, 8'd0, 2'b00, 1, "sat_down_1to0");
    vec(1, 0, 0, 0,  1, 0, 8'd0, 2'b01, 1, "sat_hold0_e2");
    vec(1, 0, 0, 0,  1, 0, 8'd0, 2'b01, 1, "sat_hold0_e3");
    vec(1, 0, 0, 0,  1, 0, 8'd0, 2'b01, 1, "sat_hold0_e4");
    vec(1, 0, 0, 0,  0, 0, 8'd0, 2'b00, 0, "sat_en0");
    vec(1, 0, 1, 13, 0, 0, 8'd9, 2'b00, 0, "sat_load_clamp");
    vec(1, 0, 0, 0,  1, 1, 8'd9, 2'b01, 1, "sat_hold9_up");
    vec(1, 0, 0, 0,  0, 1, 8'd9, 2'b00, 0, "sat_en0_at9");
    // Cascade: decimal 00..99 then wrap; tc column is the second stage's tc.
    vec(2, 1, 0, 0, 0, 1, 8'h00, 2'b00, 0, "cascade_rst");
    for (int k = 1; k <= 100; k++) begin
      v = k % 100;
      vec(2, 0, 0, 0, 1, 1, {4'(v / 10), 4'(v % 10)},
          {(k % 100) == 0, (k % 10) == 0}, (v == 99), $sformatf("cascade_%0d", k));
    end
    @(negedge clk);
    cas_en = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations pending, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
